// File: rtl/parity_run_sched_if.sv
// Request/grant bundle between requesters and the parity-run scheduler.
// N must match the scheduler's N parameter.
interface parity_run_sched_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   req;
   logic [3*N-1:0] data;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           z;
   logic           done;
   logic [IdW-1:0] done_id;
   logic           hit;
   logic           aborted;

   modport master (
      output req, data,
      input  gnt, busy, z, done, done_id, hit, aborted
   );

   modport slave (
      input  req, data,
      output gnt, busy, z, done, done_id, hit, aborted
   );
endinterface

// File: rtl/parity_run_sched.sv
// Round-robin burst scheduler that tracks runs of odd-parity beats from the granted requester
// and reports a per-burst summary on a one-cycle done pulse.
module parity_run_sched #(
   parameter int unsigned N         = 4,
   parameter int unsigned BURST_LEN = 8
) (
   input logic               clk,
   input logic               reset,
   parity_run_sched_if.slave bus
);
   localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [1:0] RunA = 2'd0;
   localparam logic [1:0] RunB = 2'd1;
   localparam logic [1:0] RunC = 2'd2;
   localparam logic [1:0] RunD = 2'd3;

   localparam logic [7:0]     LastBeat = 8'(BURST_LEN - 1);
   localparam logic [IdW-1:0] LastId   = IdW'(N - 1);
   localparam logic [IdW:0]   NumReq   = (IdW + 1)'(N);

   logic [1:0]     state_q, state_d;
   logic [IdW-1:0] winner_q, winner_d;
   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [1:0]     run_q, run_d, run_nxt;
   logic           z_q, z_d;
   logic           hit_q, hit_d;
   logic           abort_q, abort_d;

   logic           pick_found;
   logic [IdW-1:0] pick_idx;
   logic [IdW:0]   cand;
   logic           k;

   // First requesting index at or after rr_ptr_q, wrapping at N.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
         if (cand >= NumReq) cand = cand - NumReq;
         if (!pick_found && bus.req[cand[IdW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IdW-1:0];
         end
      end
   end

   always_comb begin
      k = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (winner_q == IdW'(i)) k = ^bus.data[3*i +: 3];
      end
      if (!k)                run_nxt = RunA;
      else if (run_q == RunD) run_nxt = RunD;
      else                   run_nxt = run_q + 2'd1;
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      z_d      = z_q;
      hit_d    = hit_q;
      abort_d  = abort_q;
      case (state_q)
         StIdle: begin
            gnt_d   = '0;
            cnt_d   = '0;
            run_d   = RunA;
            z_d     = 1'b0;
            hit_d   = 1'b0;
            abort_d = 1'b0;
            if (pick_found) begin
               winner_d = pick_idx;
               gnt_d    = N'(1) << pick_idx;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (!bus.req[winner_q]) begin
               // Requester withdrew: this edge is not a beat.
               state_d = StDone;
               abort_d = 1'b1;
               gnt_d   = '0;
            end else begin
               run_d = run_nxt;
               z_d   = (run_nxt == RunD);
               hit_d = hit_q | (run_nxt == RunD);
               if (cnt_q == LastBeat) begin
                  state_d = StDone;
                  gnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StDone: begin
            rr_ptr_d = (winner_q == LastId) ? '0 : winner_q + IdW'(1);
            state_d  = StIdle;
            cnt_d    = '0;
            run_d    = RunA;
            z_d      = 1'b0;
            hit_d    = 1'b0;
            abort_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
            run_d   = RunA;
            z_d     = 1'b0;
            hit_d   = 1'b0;
            abort_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         winner_q <= '0;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         cnt_q    <= '0;
         run_q    <= RunA;
         z_q      <= 1'b0;
         hit_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         z_q      <= z_d;
         hit_q    <= hit_d;
         abort_q  <= abort_d;
      end
   end

   // Burst summary is only presented during the single DONE cycle.
   assign bus.gnt     = gnt_q;
   assign bus.busy    = (state_q == StRun);
   assign bus.z       = z_q;
   assign bus.done    = (state_q == StDone);
   assign bus.done_id = (state_q == StDone) ? winner_q : '0;
   assign bus.hit     = (state_q == StDone) & hit_q;
   assign bus.aborted = (state_q == StDone) & abort_q;
endmodule
